debug_controller: RTL and testbench

Sequencer between the host serial link and the MIPS debug decoder. It receives command bytes from the UART receiver and drives the decoder's 8-bit code input. It then captures the decoder's result/size pair and streams the selected result bytes back through the UART transmitter. It also generates single-step and N-step pipeline clock pulses by sequencing the decoder's clock-low/clock-high codes, so the host never toggles the pipeline clock directly.

---
 rtl/debug_controller_pkg.sv | 22 ++
 rtl/debug_tx_serializer.sv | 60 ++++++
 rtl/debug_controller.sv | 133 +++++++++++++
 tb/tb_debug_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_controller_pkg.sv
// rtl/debug_controller_pkg.sv - shared command/code constants and FSM state encoding
package debug_controller_pkg;

   localparam logic [7:0] CMD_STEP    = 8'h80;
   localparam logic [7:0] CMD_RUN     = 8'h81;
   localparam logic [7:0] CODE_IDLE   = 8'h00;
   localparam logic [7:0] CODE_CLK_LO = 8'h38;
   localparam logic [7:0] CODE_CLK_HI = 8'h3F;
   localparam logic [7:0] ACK_BYTE    = 8'hAA;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_N,
      ST_SETTLE,
      ST_SEND,
      ST_WAIT_TX,
      ST_CLK_HI,
      ST_CLK_LO,
      ST_ACK
   } state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// rtl/debug_tx_serializer.sv - MSB-first reply shifter with UART start/busy handshake
module debug_tx_serializer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic [2:0]  load_count,
   input  logic        send_en,
   input  logic        wait_en,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        byte_done,
   output logic        last_byte
);

   logic [31:0] shift_reg;
   logic [31:0] aligned;
   logic [2:0]  byte_cnt;
   logic        guard;

   // Left-justify the low load_count bytes so the next byte is always [31:24].
   always_comb begin
      aligned = load_data;
      case (load_count)
         3'd1:    aligned = {load_data[7:0], 24'h0};
         3'd2:    aligned = {load_data[15:0], 16'h0};
         3'd3:    aligned = {load_data[23:0], 8'h0};
         default: aligned = load_data;
      endcase
   end

   always_comb begin
      tx_start  = send_en & ~tx_busy;
      tx_data   = tx_start ? shift_reg[31:24] : 8'h00;
      byte_done = wait_en & ~guard & ~tx_busy;
      last_byte = (byte_cnt == 3'd1);
   end

   // guard masks the cycle before the transmitter has raised tx_busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= 32'h0;
         byte_cnt  <= 3'd0;
         guard     <= 1'b0;
      end else if (load) begin
         shift_reg <= aligned;
         byte_cnt  <= load_count;
         guard     <= 1'b0;
      end else if (tx_start) begin
         guard <= 1'b1;
      end else if (byte_done) begin
         shift_reg <= {shift_reg[23:0], 8'h00};
         byte_cnt  <= byte_cnt - 3'd1;
      end else if (wait_en && guard) begin
         guard <= 1'b0;
      end
   end

endmodule

// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - host-command sequencer driving the MIPS debug decoder and reply path
module debug_controller
   import debug_controller_pkg::*;
#(
   parameter int SETTLE_CYCLES   = 4,
   parameter int CLK_HIGH_CYCLES = 4,
   parameter int CLK_LOW_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic [7:0]  dbg_code,
   input  logic [31:0] dbg_result,
   input  logic [1:0]  dbg_size,
   output logic        busy,
   output logic        overrun
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] HI_LAST     = 8'(CLK_HIGH_CYCLES - 1);
   localparam logic [7:0] LO_LAST     = 8'(CLK_LOW_CYCLES - 1);

   state_t      state, next_state;
   logic [7:0]  cyc_cnt;
   logic [7:0]  pulse_cnt;
   logic [7:0]  query_code;
   logic        ser_load;
   logic [31:0] ser_data;
   logic [2:0]  ser_count;
   logic        ser_byte_done;
   logic        ser_last;

   debug_tx_serializer u_tx_serializer (
      .clk        (clk),
      .reset      (reset),
      .load       (ser_load),
      .load_data  (ser_data),
      .load_count (ser_count),
      .send_en    (state == ST_SEND),
      .wait_en    (state == ST_WAIT_TX),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .byte_done  (ser_byte_done),
      .last_byte  (ser_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      ser_load   = 1'b0;
      ser_data   = dbg_result;
      ser_count  = {1'b0, dbg_size} + 3'd1;
      dbg_code   = CODE_IDLE;
      case (state)
         ST_IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_STEP)     next_state = ST_CLK_HI;
               else if (rx_data == CMD_RUN) next_state = ST_GET_N;
               else                         next_state = ST_SETTLE;
            end
         end
         ST_GET_N: begin
            if (rx_valid) next_state = (rx_data == 8'h00) ? ST_ACK : ST_CLK_HI;
         end
         ST_SETTLE: begin
            dbg_code = query_code;
            if (cyc_cnt == SETTLE_LAST) begin
               ser_load   = 1'b1;
               next_state = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_start) next_state = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (ser_byte_done) next_state = ser_last ? ST_IDLE : ST_SEND;
         end
         ST_CLK_HI: begin
            dbg_code = CODE_CLK_HI;
            if (cyc_cnt == HI_LAST) next_state = ST_CLK_LO;
         end
         ST_CLK_LO: begin
            dbg_code = CODE_CLK_LO;
            if (cyc_cnt == LO_LAST) next_state = (pulse_cnt == 8'd1) ? ST_ACK : ST_CLK_HI;
         end
         ST_ACK: begin
            ser_load   = 1'b1;
            ser_data   = {24'h0, ACK_BYTE};
            ser_count  = 3'd1;
            next_state = ST_SEND;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // cyc_cnt restarts on every state change so each timed window counts from zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt    <= 8'd0;
         pulse_cnt  <= 8'd0;
         query_code <= 8'd0;
         overrun    <= 1'b0;
      end else begin
         if (next_state != state)
            cyc_cnt <= 8'd0;
         else if (state == ST_SETTLE || state == ST_CLK_HI || state == ST_CLK_LO)
            cyc_cnt <= cyc_cnt + 8'd1;

         if (state == ST_IDLE && rx_valid) begin
            query_code <= rx_data;
            if (rx_data == CMD_STEP) pulse_cnt <= 8'd1;
         end else if (state == ST_GET_N && rx_valid) begin
            pulse_cnt <= rx_data;
         end else if (state == ST_CLK_LO && cyc_cnt == LO_LAST) begin
            pulse_cnt <= pulse_cnt - 8'd1;
         end

         if (rx_valid && state != ST_IDLE && state != ST_GET_N) overrun <= 1'b1;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_controller.sv
// tb/tb_debug_controller.sv - scoreboard bench for debug_controller replies and clock-code sequences
module tb_debug_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        tx_busy = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic [7:0]  dbg_code;
   logic [31:0] dbg_result = 32'h0;
   logic [1:0]  dbg_size = 2'b00;
   logic        busy;
   logic        overrun;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  tx_q[$];
   logic [15:0] code_q[$];
   logic        hold_busy = 1'b0;

   debug_controller dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .dbg_code   (dbg_code),
      .dbg_result (dbg_result),
      .dbg_size   (dbg_size),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // UART transmitter model: busy for 3 cycles after each start, or held by hold_busy.
   initial begin
      logic seen;
      int   busy_cnt;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         seen = tx_start;
         @(posedge clk);
         #1;
         if (seen) busy_cnt = 3;
         else if (busy_cnt > 0) busy_cnt--;
         tx_busy = hold_busy || (busy_cnt != 0);
      end
   end

   initial begin
      logic prev_start;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && tx_start) begin
            check("tx_start_while_busy", 32'(tx_busy), 32'h0);
            check("tx_start_back_to_back", 32'(prev_start), 32'h0);
            if (tx_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
            end else begin
               check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
            end
         end
         prev_start = reset ? 1'b0 : tx_start;
      end
   end

   // Collects runs of non-zero dbg_code as {code, length} and compares them in order.
   initial begin
      logic [7:0]  cur;
      int          len;
      logic [15:0] exp;
      cur = 8'h00;
      len = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cur = 8'h00;
            len = 0;
         end else if (dbg_code == cur) begin
            len++;
         end else begin
            if (cur != 8'h00) begin
               if (code_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL code_unexpected: got code 0x%0h for %0d cycles, expected none", cur, len);
               end else begin
                  exp = code_q.pop_front();
                  check("code_value", 32'(cur), 32'(exp[15:8]));
                  check("code_len", 32'(len), 32'(exp[7:0]));
               end
            end
            cur = dbg_code;
            len = 1;
         end
      end
   end

   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 400 && busy; i++) @(negedge clk);
      check(name, 32'(busy), 32'h0);
   endtask

   task automatic push_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         code_q.push_back({8'h3F, 8'd4});
         code_q.push_back({8'h38, 8'd4});
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_dbg_code", 32'(dbg_code), 32'h00);
      check("reset_tx_start", 32'(tx_start), 32'h0);
      check("reset_tx_data", 32'(tx_data), 32'h00);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_overrun", 32'(overrun), 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      dbg_result = 32'h12345678;
      dbg_size   = 2'b11;
      code_q.push_back({8'h0A, 8'd4});
      tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h56); tx_q.push_back(8'h78);
      send_rx(8'h0A);
      wait_idle("query_reg1_idle");

      dbg_result = 32'h00000009;
      dbg_size   = 2'b00;
      code_q.push_back({8'h02, 8'd4});
      tx_q.push_back(8'h09);
      send_rx(8'h02);
      wait_idle("byte_query_idle");
      check("byte_query_busy_after_tx", 32'(tx_busy), 32'h0);

      push_pulses(1);
      tx_q.push_back(8'hAA);
      send_rx(8'h80);
      wait_idle("step_idle");

      push_pulses(3);
      tx_q.push_back(8'hAA);
      send_rx(8'h81);
      send_rx(8'h03);
      wait_idle("run3_idle");

      tx_q.push_back(8'hAA);
      send_rx(8'h81);
      send_rx(8'h00);
      wait_idle("run0_idle");

      dbg_result = 32'hDEADBEEF;
      dbg_size   = 2'b11;
      check("overrun_before", 32'(overrun), 32'h0);
      code_q.push_back({8'h05, 8'd4});
      tx_q.push_back(8'hDE); tx_q.push_back(8'hAD); tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
      send_rx(8'h05);
      for (int i = 0; i < 50 && !tx_start; i++) @(negedge clk);
      check("backpressure_first_start", 32'(tx_start), 32'h1);
      hold_busy = 1'b1;
      repeat (4) @(negedge clk);
      send_rx(8'h55);
      repeat (14) @(negedge clk);
      hold_busy = 1'b0;
      wait_idle("backpressure_idle");
      check("overrun_set", 32'(overrun), 32'h1);

      send_rx(8'h81);
      send_rx(8'h05);
      for (int i = 0; i < 50 && dbg_code !== 8'h3F; i++) @(negedge clk);
      check("run5_clk_hi", 32'(dbg_code), 32'h3F);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_dbg_code", 32'(dbg_code), 32'h00);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_tx_start", 32'(tx_start), 32'h0);
      check("abort_overrun", 32'(overrun), 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      dbg_result = 32'hCAFEF00D;
      dbg_size   = 2'b01;
      code_q.push_back({8'h1F, 8'd4});
      tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
      send_rx(8'h1F);
      wait_idle("post_reset_query_idle");

      repeat (5) @(negedge clk);
      check("tx_queue_drained", 32'(tx_q.size()), 32'h0);
      check("code_queue_drained", 32'(code_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
